cp0_int_seq: RTL and testbench
==============================

Name: cp0_int_seq

Overview:
- Interrupt/exception sequencer for the multi-cycle MIPS core.
- Samples the CP0 interrupt request at instruction boundaries, then drives the CP0 control strobes (EPCWr, EXLSet, EXLClr) and the PC override in a fixed order.
- Also sequences ERET.
- Sits between the multi-cycle control FSM, the PC register and the CP0 register file. It is the only driver of the CP0 control strobes.

Parameters:
- HANDLER_ADDR, 32'h0000_4180: byte address of the common interrupt handler.
- VEC_STRIDE, 32'h0000_0020: byte spacing between vectored handler entries (used only with the optional feature).
- CNT_W, 16: width of the taken-interrupt counter.

Ports:
- clk  in  1: system clock, rising edge.
- reset  in  1: synchronous, active-high reset.
- IntReq  in  1: CP0 interrupt request (already gated by IE, IM and EXL).
- HWInt  in  6: raw hardware interrupt lines.
- im  in  6: CP0 SR.IM field.
- instr_end  in  1: last cycle of the current instruction; npc is valid.
- eret  in  1: current instruction is ERET; qualified by instr_end.
- npc  in  30: word address of the next instruction.
- epc  in  30: CP0 EPC (word address).
- cpu_hold  out  1: freezes the control FSM and PC/IR writes.
- EPCWr  out  1: CP0 EPC write strobe.
- EXLSet  out  1: CP0 EXL set strobe.
- EXLClr  out  1: CP0 EXL clear strobe.
- epc_pc  out  30: value for CP0 to capture into EPC.
- pc_ovr  out  1: PC override write enable.
- pc_ovr_val  out  32: PC override value (byte address).
- int_id  out  3: index of the interrupt taken, 5..0; 3'd7 means none since reset.
- int_cnt  out  CNT_W: number of interrupts taken, saturating.

Behaviour:
- States: RUN, SAVE, VECTOR, RET. The FSM is Moore: all strobes decode from the state alone.
- Reset (sync, active-high) forces:
  - state RUN
  - cpu_hold, EPCWr, EXLSet, EXLClr, pc_ovr all 0
  - epc_pc 0, pc_ovr_val 0
  - int_id 3'd7
  - int_cnt 0
  - Reset overrides any state mid-sequence: no partial strobe is issued in the reset cycle, and the state is RUN on the next cycle.
- RUN: all outputs inactive, cpu_hold=0, pc_ovr_val=0.
  - If instr_end & eret: go to RET. ERET wins over a simultaneous IntReq; the interrupt is retaken at a later boundary.
  - Else if instr_end & IntReq:
    - latch npc into epc_pc
    - latch int_id = highest set bit of (HWInt & im), bit 5 having highest priority
    - if HWInt & im == 0 (not a legal case), int_id = 0
    - increment int_cnt, saturating at all-ones
    - go to SAVE
  - IntReq without instr_end is ignored; no mid-instruction entry.
- SAVE (exactly 1 cycle): EPCWr=1, EXLSet=1, cpu_hold=1. epc_pc holds the latched npc. Go to VECTOR.
- VECTOR (exactly 1 cycle): pc_ovr=1, pc_ovr_val=HANDLER_ADDR, cpu_hold=1. Go to RUN.
- RET (exactly 1 cycle): EXLClr=1, pc_ovr=1, pc_ovr_val={epc,2'b00}, cpu_hold=1. Go to RUN.
- Timing:
  - Latency from the boundary cycle to the handler PC written is 2 clocks.
  - The first handler fetch happens in the cycle after VECTOR.
  - ERET return PC is written 1 clock after the boundary.
- Input sampling outside RUN:
  - IntReq, HWInt, eret and instr_end are ignored in SAVE, VECTOR and RET.
  - A drop of IntReq after the latch does not abort the sequence.
- Outputs held outside SAVE:
  - epc_pc holds its last latched value.
  - int_id holds until the next taken interrupt.
- EPCWr and EXLSet are never asserted in the same cycle as EXLClr.
- pc_ovr is never asserted in SAVE.

Optional Feature:
- Macro INT_VECTORED_EN.
- Defined: in VECTOR, pc_ovr_val = HANDLER_ADDR + int_id*VEC_STRIDE, computed mod 2^32.
- Undefined: pc_ovr_val = HANDLER_ADDR for every interrupt. int_id is still produced.

Test Plan:
- Reset: assert reset for 2 cycles mid-SAVE → next cycle state RUN, all strobes 0, int_id=7, int_cnt=0.
- Basic entry: HWInt=6'b000100, im=6'b111111, IntReq=1, instr_end=1, npc=30'h0000_0C05 → next cycle EPCWr=EXLSet=1 with epc_pc=30'h0C05; following cycle pc_ovr=1 with pc_ovr_val=32'h0000_4180; int_id=2, int_cnt=1.
- Priority: HWInt=6'b100001, im=6'b111111 at a boundary → int_id=5. With INT_VECTORED_EN: pc_ovr_val=32'h0000_4220.
- ERET with simultaneous IntReq: eret=1, instr_end=1, IntReq=1, epc=30'h0000_0C05 → next cycle EXLClr=1, pc_ovr=1, pc_ovr_val=32'h0000_3014; EPCWr=0 throughout; int_cnt unchanged.
- No boundary: IntReq=1 for 10 cycles with instr_end=0 → no strobes, cpu_hold=0. Then instr_end=1 → SAVE in the next cycle.
- Counter saturation: CNT_W=2, take 5 interrupts → int_cnt reads 3 after the third and stays 3.

Source files
------------

// File: rtl/cp0_int_seq.sv
// cp0_int_seq -- interrupt / ERET sequencer for the multi-cycle MIPS core.
//
// Samples the CP0 interrupt request only at instruction boundaries, then walks
// RUN -> SAVE -> VECTOR -> RUN, issuing the EPC write / EXL set strobes and the
// PC override to the handler. ERET walks RUN -> RET -> RUN, clearing EXL and
// reloading the PC from EPC. This block is the only driver of the CP0 strobes.
//
// Optional build macro: INT_VECTORED_EN -- when defined, the VECTOR override is
// HANDLER_ADDR + int_id*VEC_STRIDE instead of the common HANDLER_ADDR.
//
// Ports:
//   clk, reset           rising-edge clock, synchronous active-high reset
//   IntReq               gated CP0 interrupt request
//   HWInt, im            raw interrupt lines and SR.IM (for int_id priority)
//   instr_end, eret      instruction boundary; ERET qualifier
//   npc, epc             next-instruction word address; CP0 EPC word address
//   cpu_hold             freezes control FSM and PC/IR writes
//   EPCWr/EXLSet/EXLClr  CP0 control strobes
//   epc_pc               value CP0 captures into EPC
//   pc_ovr, pc_ovr_val   PC override enable / byte address
//   int_id, int_cnt      last taken interrupt index (7 = none), taken count

module cp0_int_seq #(
  parameter logic [31:0] HANDLER_ADDR = 32'h0000_4180,
  parameter logic [31:0] VEC_STRIDE   = 32'h0000_0020,
  parameter int          CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             IntReq,
  input  logic [5:0]       HWInt,
  input  logic [5:0]       im,
  input  logic             instr_end,
  input  logic             eret,
  input  logic [29:0]      npc,
  input  logic [29:0]      epc,
  output logic             cpu_hold,
  output logic             EPCWr,
  output logic             EXLSet,
  output logic             EXLClr,
  output logic [29:0]      epc_pc,
  output logic             pc_ovr,
  output logic [31:0]      pc_ovr_val,
  output logic [2:0]       int_id,
  output logic [CNT_W-1:0] int_cnt
);

  typedef enum logic [1:0] {RUN, SAVE, VECTOR, RET} state_t;

  state_t           r_state, w_next;
  logic [29:0]      r_epc_pc;
  logic [2:0]       r_int_id;
  logic [CNT_W-1:0] r_int_cnt;
  logic [5:0]       w_masked;
  logic [2:0]       w_prio;
  logic             w_take;
  logic [31:0]      w_vec_addr;

  // Ascending scan so the highest set bit wins; an empty mask leaves 0.
  always_comb begin
    w_masked = HWInt & im;
    w_prio   = 3'd0;
    for (int i = 0; i < 6; i++)
      if (w_masked[i]) w_prio = 3'(i);
  end

  // ERET takes precedence at a boundary; the interrupt is retaken later.
  assign w_take = (r_state == RUN) && instr_end && !eret && IntReq;

`ifdef INT_VECTORED_EN
  assign w_vec_addr = HANDLER_ADDR + 32'(r_int_id) * VEC_STRIDE;
`else
  assign w_vec_addr = HANDLER_ADDR;
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      RUN: begin
        if (instr_end && eret)      w_next = RET;
        else if (instr_end && IntReq) w_next = SAVE;
      end
      SAVE:    w_next = VECTOR;
      VECTOR:  w_next = RUN;
      RET:     w_next = RUN;
      default: w_next = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= RUN;
    else       r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_epc_pc  <= '0;
      r_int_id  <= 3'd7;
      r_int_cnt <= '0;
    end else if (w_take) begin
      r_epc_pc <= npc;
      r_int_id <= w_prio;
      if (r_int_cnt != {CNT_W{1'b1}}) r_int_cnt <= r_int_cnt + 1'b1;
    end
  end

  // Strobes decode from state only; reset masks them so a sequence cut short
  // by reset never emits a partial strobe in the reset cycle.
  always_comb begin
    cpu_hold   = 1'b0;
    EPCWr      = 1'b0;
    EXLSet     = 1'b0;
    EXLClr     = 1'b0;
    pc_ovr     = 1'b0;
    pc_ovr_val = 32'h0;
    if (!reset) begin
      case (r_state)
        SAVE: begin
          cpu_hold = 1'b1;
          EPCWr    = 1'b1;
          EXLSet   = 1'b1;
        end
        VECTOR: begin
          cpu_hold   = 1'b1;
          pc_ovr     = 1'b1;
          pc_ovr_val = w_vec_addr;
        end
        RET: begin
          cpu_hold   = 1'b1;
          EXLClr     = 1'b1;
          pc_ovr     = 1'b1;
          pc_ovr_val = {epc, 2'b00};
        end
        default: ;
      endcase
    end
  end

  assign epc_pc  = r_epc_pc;
  assign int_id  = r_int_id;
  assign int_cnt = r_int_cnt;

endmodule

// File: tb/tb_cp0_int_seq.sv
module tb_cp0_int_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        IntReq, instr_end, eret;
  logic [5:0]  HWInt, im;
  logic [29:0] npc, epc;

  logic        a_hold, a_epcwr, a_exlset, a_exlclr, a_ovr;
  logic [29:0] a_epc;
  logic [31:0] a_val;
  logic [2:0]  a_id;
  logic [15:0] a_cnt;
  logic        b_hold, b_epcwr, b_exlset, b_exlclr, b_ovr;
  logic [29:0] b_epc;
  logic [31:0] b_val;
  logic [2:0]  b_id;
  logic [1:0]  b_cnt;

  always #5 clk = ~clk;

  cp0_int_seq u_dut (
    .clk(clk), .reset(reset), .IntReq(IntReq), .HWInt(HWInt), .im(im),
    .instr_end(instr_end), .eret(eret), .npc(npc), .epc(epc),
    .cpu_hold(a_hold), .EPCWr(a_epcwr), .EXLSet(a_exlset), .EXLClr(a_exlclr),
    .epc_pc(a_epc), .pc_ovr(a_ovr), .pc_ovr_val(a_val), .int_id(a_id), .int_cnt(a_cnt)
  );

  cp0_int_seq #(.CNT_W(2)) u_sat (
    .clk(clk), .reset(reset), .IntReq(IntReq), .HWInt(HWInt), .im(im),
    .instr_end(instr_end), .eret(eret), .npc(npc), .epc(epc),
    .cpu_hold(b_hold), .EPCWr(b_epcwr), .EXLSet(b_exlset), .EXLClr(b_exlclr),
    .epc_pc(b_epc), .pc_ovr(b_ovr), .pc_ovr_val(b_val), .int_id(b_id), .int_cnt(b_cnt)
  );

  typedef struct packed {
    logic        hold, epcwr, exlset, exlclr, ovr;
    logic [31:0] val;
    logic [29:0] epc;
    logic [2:0]  id;
    logic [15:0] cnt;
    logic [1:0]  cnt2;
  } exp_t;

  exp_t  sb_q[$];
  string tag_q[$];
  int    tests = 0, fails = 0;

  // Bench-side architectural state of the last taken interrupt.
  logic [29:0] m_epc = '0;
  logic [2:0]  m_id  = 3'd7;
  logic [15:0] m_cnt = '0;
  logic [1:0]  m_cnt2 = '0;

  function automatic logic [31:0] handler(input logic [2:0] id);
`ifdef INT_VECTORED_EN
    return 32'h0000_4180 + 32'(id) * 32'h20;
`else
    return 32'h0000_4180 + 32'(id) * 32'h0;
`endif
  endfunction

  function automatic exp_t mk(input logic [4:0] st, input logic [31:0] val);
    exp_t e;
    {e.hold, e.epcwr, e.exlset, e.exlclr, e.ovr} = st;
    e.val = val; e.epc = m_epc; e.id = m_id; e.cnt = m_cnt; e.cnt2 = m_cnt2;
    return e;
  endfunction

  function automatic exp_t e_run();  return mk(5'b00000, 32'h0);          endfunction
  function automatic exp_t e_save(); return mk(5'b11100, 32'h0);          endfunction
  function automatic exp_t e_vec();  return mk(5'b10001, handler(m_id));  endfunction

  task automatic cmp(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    assert (act === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic check_pop();
    exp_t e; string t;
    e = sb_q.pop_front(); t = tag_q.pop_front();
    cmp({t, ".hold"},   32'(a_hold),   32'(e.hold));
    cmp({t, ".epcwr"},  32'(a_epcwr),  32'(e.epcwr));
    cmp({t, ".exlset"}, 32'(a_exlset), 32'(e.exlset));
    cmp({t, ".exlclr"}, 32'(a_exlclr), 32'(e.exlclr));
    cmp({t, ".ovr"},    32'(a_ovr),    32'(e.ovr));
    cmp({t, ".val"},    a_val,         e.val);
    cmp({t, ".epc"},    32'(a_epc),    32'(e.epc));
    cmp({t, ".id"},     32'(a_id),     32'(e.id));
    cmp({t, ".cnt"},    32'(a_cnt),    32'(e.cnt));
    cmp({t, ".s_hold"}, 32'({b_hold, b_epcwr, b_exlset, b_exlclr, b_ovr}),
        32'({e.hold, e.epcwr, e.exlset, e.exlclr, e.ovr}));
    cmp({t, ".s_val"},  b_val,         e.val);
    cmp({t, ".s_id"},   32'(b_id),     32'(e.id));
    cmp({t, ".s_cnt2"}, 32'(b_cnt),    32'(e.cnt2));
  endtask

  // Push the expectation for the state after the next edge, clock, compare.
  task automatic cyc(input string tag, input exp_t e);
    sb_q.push_back(e); tag_q.push_back(tag);
    @(posedge clk); #1;
    check_pop();
  endtask

  task automatic now(input string tag, input exp_t e);
    sb_q.push_back(e); tag_q.push_back(tag);
    #1;
    check_pop();
  endtask

  task automatic idle();
    IntReq = 0; instr_end = 0; eret = 0; HWInt = '0; npc = '0;
  endtask

  task automatic note_take(input logic [29:0] n, input logic [2:0] id);
    m_epc = n; m_id = id;
    if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 1'b1;
    if (m_cnt2 != 2'b11)   m_cnt2 = m_cnt2 + 1'b1;
  endtask

  task automatic take(input string tag, input logic [5:0] hw, input logic [5:0] msk,
                      input logic [29:0] n, input logic [2:0] id);
    HWInt = hw; im = msk; npc = n; IntReq = 1; instr_end = 1; eret = 0;
    note_take(n, id);
    cyc({tag, "_save"}, e_save());
    idle();
    cyc({tag, "_vec"}, e_vec());
    cyc({tag, "_run"}, e_run());
  endtask

  initial begin
    reset = 1; im = 6'h3F; epc = '0; idle();
    cyc("reset0", e_run());
    cyc("reset1", e_run());
    reset = 0;
    cyc("idle", e_run());

    // Basic entry, with IntReq dropped after the latch.
    take("basic", 6'b000100, 6'h3F, 30'h0000_0C05, 3'd2);

    // Priority; inputs during SAVE must be ignored.
    HWInt = 6'b100001; im = 6'h3F; npc = 30'h0000_0123; IntReq = 1; instr_end = 1;
    note_take(30'h0000_0123, 3'd5);
    cyc("prio_save", e_save());
    eret = 1; instr_end = 1; IntReq = 1; npc = 30'h3FFF_FFFF;
    cyc("prio_vec", e_vec());
    cmp("prio_vec_addr", a_val, handler(3'd5));
    idle();
    cyc("prio_run", e_run());

    // ERET wins over simultaneous IntReq.
    eret = 1; instr_end = 1; IntReq = 1; HWInt = 6'b000001; epc = 30'h0000_0C05;
    cyc("eret_ret", mk(5'b10011, 32'h0000_3014));
    idle();
    cyc("eret_run", e_run());

    // IntReq without a boundary is ignored.
    IntReq = 1; HWInt = 6'b000010; instr_end = 0;
    for (int i = 0; i < 10; i++) cyc("noboundary", e_run());
    instr_end = 1; npc = 30'h0000_0AAA;
    note_take(30'h0000_0AAA, 3'd1);
    cyc("boundary_save", e_save());
    idle();
    cyc("boundary_vec", e_vec());
    cyc("boundary_run", e_run());

    // Counter saturation (narrow instance) and empty-mask id.
    take("emptymask", 6'b000001, 6'h00, 30'h0000_0111, 3'd0);
    take("sat5", 6'b001000, 6'h3F, 30'h0000_0222, 3'd3);

    // Reset arriving mid-SAVE.
    HWInt = 6'b010000; im = 6'h3F; npc = 30'h0000_0333; IntReq = 1; instr_end = 1;
    note_take(30'h0000_0333, 3'd4);
    cyc("rst_save", e_save());
    idle();
    reset = 1;
    now("rst_cycle", e_run());
    m_epc = '0; m_id = 3'd7; m_cnt = '0; m_cnt2 = '0;
    cyc("rst_hold0", e_run());
    cyc("rst_hold1", e_run());
    reset = 0;
    cyc("rst_after", e_run());
    take("post_rst", 6'b100000, 6'h3F, 30'h0000_0444, 3'd5);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
